// File: rtl/raisin64_io_pkg.sv
// Shared constants for the raisin64 memory-mapped IO bridge: bus widths and the
// IO region map.
package raisin64_io_pkg;

  localparam int unsigned AddrW = 64;
  localparam int unsigned DataW = 64;
  localparam int unsigned LedW  = 16;
  localparam int unsigned SwW   = 16;

  localparam logic [AddrW-1:0] LED_ADDR = 64'h0000_0000_F000_0000;
  localparam logic [AddrW-1:0] SW_ADDR  = 64'h0000_0000_F000_0008;
  localparam logic [AddrW-1:0] VGA_BASE = 64'h0000_0000_F001_0000;
  localparam logic [AddrW-1:0] VGA_SIZE = 64'h0000_0000_0001_0000;

endpackage

// File: rtl/io_addr_decode.sv
// Combinational IO region decoder; hits are prioritised led > sw > vga so that at
// most one is ever asserted, even if the address map is misconfigured.
module io_addr_decode
  import raisin64_io_pkg::*;
#(
  parameter logic [AddrW-1:0] LedAddr = LED_ADDR,
  parameter logic [AddrW-1:0] SwAddr  = SW_ADDR,
  parameter logic [AddrW-1:0] VgaBase = VGA_BASE,
  parameter logic [AddrW-1:0] VgaSize = VGA_SIZE
) (
  input  logic [AddrW-1:0] addr_i,
  input  logic             valid_i,
  output logic             led_hit_o,
  output logic             sw_hit_o,
  output logic             vga_hit_o
);

  localparam logic [AddrW-1:0] VgaMask = ~(VgaSize - 64'd1);

  logic [AddrW-1:0] addr_eff;
  logic             led_raw;
  logic             sw_raw;
  logic             vga_raw;

  always_comb begin
    addr_eff = valid_i ? addr_i : '0;
    led_raw  = valid_i && (addr_eff[AddrW-1:3] == LedAddr[AddrW-1:3]);
    sw_raw   = valid_i && (addr_eff[AddrW-1:3] == SwAddr[AddrW-1:3]);
    vga_raw  = valid_i && ((addr_eff & VgaMask) == VgaBase);

    led_hit_o = led_raw;
    sw_hit_o  = sw_raw & ~led_raw;
    vga_hit_o = vga_raw & ~led_raw & ~sw_raw;
  end

endmodule

// File: rtl/raisin64_io_bridge.sv
// raisin64 external-bus IO bridge: LED register, synchronised switches and a
// zero-wait-state VGA passthrough window.
module raisin64_io_bridge
  import raisin64_io_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AddrW-1:0] mem_addr,
  input  logic             mem_addr_valid,
  input  logic [DataW-1:0] mem_dout,
  input  logic             mem_dout_write,
  output logic [DataW-1:0] mem_din,
  output logic             mem_din_ready,
  input  logic [SwW-1:0]   sw,
  output logic [LedW-1:0]  led,
  output logic             vga_sel,
  output logic [AddrW-1:0] vga_addr,
  output logic             vga_we,
  output logic [DataW-1:0] vga_wdata,
  input  logic [DataW-1:0] vga_rdata
);

  logic            led_hit;
  logic            sw_hit;
  logic            vga_hit;
  logic [LedW-1:0] led_q;
  logic [LedW-1:0] led_d;
  logic [SwW-1:0]  sw_s1_q;
  logic [SwW-1:0]  sw_s0_q;

  io_addr_decode #(
    .LedAddr (LED_ADDR),
    .SwAddr  (SW_ADDR),
    .VgaBase (VGA_BASE),
    .VgaSize (VGA_SIZE)
  ) u_decode (
    .addr_i    (mem_addr),
    .valid_i   (mem_addr_valid),
    .led_hit_o (led_hit),
    .sw_hit_o  (sw_hit),
    .vga_hit_o (vga_hit)
  );

  always_comb begin
    led_d = led_q;
    if (led_hit && mem_addr_valid && mem_dout_write) begin
      led_d = mem_dout[LedW-1:0];
    end
  end

  // Reset wins over a same-cycle LED write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q   <= '0;
      sw_s1_q <= '0;
      sw_s0_q <= '0;
    end else begin
      led_q   <= led_d;
      sw_s1_q <= sw;
      sw_s0_q <= sw_s1_q;
    end
  end

  always_comb begin
    mem_din = '0;
    if (led_hit) begin
      mem_din = {{(DataW-LedW){1'b0}}, led_q};
    end else if (sw_hit) begin
      mem_din = {{(DataW-SwW){1'b0}}, sw_s0_q};
    end else if (vga_hit) begin
      mem_din = vga_rdata;
    end
  end

  assign mem_din_ready = mem_addr_valid;
  assign led           = led_q;
  assign vga_sel       = vga_hit & mem_addr_valid;
  assign vga_we        = vga_sel & mem_dout_write;
  assign vga_addr      = mem_addr - VGA_BASE;
  assign vga_wdata     = mem_dout;

endmodule

// File: tb/tb_raisin64_io_bridge.sv
// Self-checking bench for raisin64_io_bridge: vector table through a scoreboard
// queue, plus hand-written reset, switch-sync and reset/write collision sequences.
module tb_raisin64_io_bridge;

  logic        clk;
  logic        rst_n;
  logic [63:0] mem_addr;
  logic        mem_addr_valid;
  logic [63:0] mem_dout;
  logic        mem_dout_write;
  logic [63:0] mem_din;
  logic        mem_din_ready;
  logic [15:0] sw;
  logic [15:0] led;
  logic        vga_sel;
  logic [63:0] vga_addr;
  logic        vga_we;
  logic [63:0] vga_wdata;
  logic [63:0] vga_rdata;

  int n_pass;
  int n_total;

  raisin64_io_bridge dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_addr_valid (mem_addr_valid),
    .mem_dout       (mem_dout),
    .mem_dout_write (mem_dout_write),
    .mem_din        (mem_din),
    .mem_din_ready  (mem_din_ready),
    .sw             (sw),
    .led            (led),
    .vga_sel        (vga_sel),
    .vga_addr       (vga_addr),
    .vga_we         (vga_we),
    .vga_wdata      (vga_wdata),
    .vga_rdata      (vga_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        write;
    logic [63:0] addr;
    logic [63:0] dout;
    logic [63:0] rdata;
    logic [63:0] exp_din;
    logic        exp_ready;
    logic        exp_sel;
    logic        exp_we;
    logic [63:0] exp_vaddr;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic valid, input logic write, input logic [63:0] addr,
                       input logic [63:0] dout, input logic [63:0] rdata);
    mem_addr_valid = valid;
    mem_dout_write = write;
    mem_addr       = addr;
    mem_dout       = dout;
    vga_rdata      = rdata;
  endtask

  task automatic add(input string name, input logic valid, input logic write,
                     input logic [63:0] addr, input logic [63:0] dout,
                     input logic [63:0] rdata, input logic [63:0] exp_din,
                     input logic exp_sel, input logic [15:0] exp_led);
    vec_t v;
    v.name      = name;
    v.valid     = valid;
    v.write     = write;
    v.addr      = addr;
    v.dout      = dout;
    v.rdata     = rdata;
    v.exp_din   = exp_din;
    v.exp_ready = valid;
    v.exp_sel   = exp_sel;
    v.exp_we    = exp_sel & write;
    v.exp_vaddr = addr - 64'h0000_0000_F001_0000;
    v.exp_led   = exp_led;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    sw = 16'hFFFF;
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);

    // Reset: two cycles held low, then synchroniser needs two edges.
    repeat (2) @(posedge clk);
    #1;
    check("reset_led", {48'h0, led}, 64'h0);
    check("reset_ready_idle", {63'h0, mem_din_ready}, 64'h0);
    check("reset_din_idle", mem_din, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 64'h0000_0000_F000_0008, 64'h0, 64'h0);
    #1;
    check("sw_after_reset_e0", mem_din, 64'h0);
    @(posedge clk); #1;
    check("sw_after_reset_e1", mem_din, 64'h0);
    @(posedge clk); #1;
    check("sw_after_reset_e2", mem_din, 64'hFFFF);

    // Vector table (led state accumulates; sw_s0 is 16'hFFFF throughout).
    add("led_write", 1, 1, 64'h0000_0000_F000_0000, 64'hDEAD_BEEF_CAFE_1234, 64'h0,
        64'h0, 0, 16'h1234);
    add("led_read", 1, 0, 64'h0000_0000_F000_0000, 64'h0, 64'h0, 64'h1234, 0, 16'h1234);
    add("led_read_lowbits", 1, 0, 64'h0000_0000_F000_0005, 64'h0, 64'h0, 64'h1234, 0,
        16'h1234);
    add("led_write_invalid", 0, 1, 64'h0000_0000_F000_0000, 64'h5555, 64'h0, 64'h0, 0,
        16'h1234);
    add("write_addr0", 1, 1, 64'h0, 64'h7777, 64'h0, 64'h0, 0, 16'h1234);
    add("unmapped_read", 1, 0, 64'h0000_0000_F000_0010, 64'h0, 64'h0, 64'h0, 0, 16'h1234);
    add("vga_read", 1, 0, 64'h0000_0000_F001_0018, 64'h0, 64'h55, 64'h55, 1, 16'h1234);
    add("vga_write", 1, 1, 64'h0000_0000_F001_0018, 64'h0123_4567_89AB_CDEF, 64'h55,
        64'h55, 1, 16'h1234);
    add("vga_top", 1, 0, 64'h0000_0000_F001_FFF8, 64'h0, 64'h99, 64'h99, 1, 16'h1234);
    add("vga_past_end", 1, 0, 64'h0000_0000_F002_0000, 64'h0, 64'h99, 64'h0, 0, 16'h1234);
    add("sw_write_ignored", 1, 1, 64'h0000_0000_F000_0008, 64'h1111, 64'h0, 64'hFFFF, 0,
        16'h1234);
    add("led_upper_discard", 1, 1, 64'h0000_0000_F000_0000, 64'hFFFF_FFFF_FFFF_00A5,
        64'h0, 64'h1234, 0, 16'h00A5);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].dout, vecs[i].rdata);
      sb.push_back(vecs[i]);
      #1;
      v = sb.pop_front();
      check({v.name, "_din"}, mem_din, v.exp_din);
      check({v.name, "_ready"}, {63'h0, mem_din_ready}, {63'h0, v.exp_ready});
      check({v.name, "_sel"}, {63'h0, vga_sel}, {63'h0, v.exp_sel});
      check({v.name, "_we"}, {63'h0, vga_we}, {63'h0, v.exp_we});
      check({v.name, "_vaddr"}, vga_addr, v.exp_vaddr);
      check({v.name, "_wdata"}, vga_wdata, v.dout);
      @(posedge clk); #1;
      check({v.name, "_led"}, {48'h0, led}, {48'h0, v.exp_led});
    end

    // Switch change at cycle N: old value at N and N+1, new from N+2.
    @(negedge clk);
    sw = 16'h1234;
    drive(1'b1, 1'b0, 64'h0000_0000_F000_0008, 64'h0, 64'h0);
    #1;
    check("sw_sync_n", mem_din, 64'hFFFF);
    @(posedge clk); #1;
    check("sw_sync_n1", mem_din, 64'hFFFF);
    @(posedge clk); #1;
    check("sw_sync_n2", mem_din, 64'h1234);

    // Reset in the same cycle as an LED write.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 64'h0000_0000_F000_0000, 64'hAAAA, 64'h0);
    @(posedge clk); #1;
    check("reset_vs_write_led", {48'h0, led}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    @(posedge clk); #1;
    check("after_collision_led", {48'h0, led}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
